// File: rtl/nibble_add_sequencer.sv
// rtl/nibble_add_sequencer.sv - nibble-serial add/sub over a shared external 4-bit adder slice
// Two requesters are round-robin arbitrated; results return on one channel tagged with the requester id.
module nibble_add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [4*NIBBLES-1:0] req0_a,
  input  logic [4*NIBBLES-1:0] req0_b,
  input  logic                 req0_sub,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [4*NIBBLES-1:0] req1_a,
  input  logic [4*NIBBLES-1:0] req1_b,
  input  logic                 req1_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [4*NIBBLES-1:0] rsp_sum,
  output logic                 rsp_cout,
  output logic                 rsp_ovf,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_s,
  input  logic                 add_cout
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;

  logic          last_gnt;
  logic          gnt0, gnt1, accept, last_nibble;
  logic [W-1:0]  a_q, b_q, sum_q;
  logic          carry, cout_q, ovf_q, id_q;
  logic [IW-1:0] idx;

  // last_gnt = 1 means requester 1 was served last, so requester 0 wins a tie.
  assign gnt0        = req0_valid & (~req1_valid | last_gnt);
  assign gnt1        = req1_valid & (~req0_valid | ~last_gnt);
  assign accept      = (state == IDLE) & (gnt0 | gnt1);
  assign last_nibble = (state == RUN) & (idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (idx == LAST) state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    add_a      = 4'h0;
    add_b      = 4'h0;
    add_cin    = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = gnt0;
        req1_ready = gnt1;
      end
      RUN: begin
        add_a   = a_q[4*idx +: 4];
        add_b   = b_q[4*idx +: 4];
        add_cin = carry;
      end
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Subtract is A + ~B + 1: B is inverted at accept and the +1 rides in as the first carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry    <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      id_q     <= 1'b0;
      idx      <= '0;
    end else if (accept) begin
      last_gnt <= gnt1;
      id_q     <= gnt1;
      a_q      <= gnt1 ? req1_a : req0_a;
      b_q      <= gnt1 ? (req1_sub ? ~req1_b : req1_b) : (req0_sub ? ~req0_b : req0_b);
      carry    <= gnt1 ? req1_sub : req0_sub;
      idx      <= '0;
    end else if (state == RUN) begin
      sum_q[4*idx +: 4] <= add_s;
      carry             <= add_cout;
      idx               <= idx + 1'b1;
      if (last_nibble) begin
        cout_q <= add_cout;
        ovf_q  <= add_a[3] ^ add_b[3] ^ add_s[3] ^ add_cout;
      end
    end
  end

  assign rsp_id   = id_q;
  assign rsp_sum  = sum_q;
  assign rsp_cout = cout_q;
  assign rsp_ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// tb/tb_nibble_add_sequencer.sv - scoreboard bench for nibble_add_sequencer with a behavioural adder slice
module tb_nibble_add_sequencer;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_sub = 1'b0, req1_sub = 1'b0;
  logic         rsp_valid, rsp_id, rsp_cout, rsp_ovf;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_sum;
  logic [3:0]   add_a, add_b, add_s;
  logic         add_cin, add_cout;

  always #5 clk = ~clk;

  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  nibble_add_sequencer #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout)
  );

  typedef struct packed {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } rsp_t;

  rsp_t sb[$];
  rsp_t exp0, exp1, e;
  int   tests = 0, fails = 0;
  int   grant_log[$];
  int   ready0_cnt = 0, ready1_cnt = 0, both_ready = 0;
  bit   log_grants = 1'b0;
  logic [3:0] cin_seq;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected result enters the scoreboard at the request handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_ready && req1_ready) both_ready++;
      if (log_grants && req0_ready) ready0_cnt++;
      if (log_grants && req1_ready) ready1_cnt++;
      if (req0_valid && req0_ready) begin
        sb.push_back(exp0);
        if (log_grants) grant_log.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        sb.push_back(exp1);
        if (log_grants) grant_log.push_back(1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected: got id=%0d sum=0x%0h with empty scoreboard", rsp_id, rsp_sum);
      end else begin
        e = sb.pop_front();
        if ({rsp_id, rsp_sum, rsp_cout, rsp_ovf} !== e) begin
          fails++;
          $display("FAIL rsp: got id=%0d sum=0x%0h cout=%0d ovf=%0d expected id=%0d sum=0x%0h cout=%0d ovf=%0d",
                   rsp_id, rsp_sum, rsp_cout, rsp_ovf, e.id, e.sum, e.cout, e.ovf);
        end
      end
    end
  end

  task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input bit sub, input rsp_t ex);
    int n = 0;
    @(posedge clk); #1;
    if (!id) begin
      req0_a = a; req0_b = b; req0_sub = sub; exp0 = ex; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_sub = sub; exp1 = ex; req1_valid = 1'b1;
    end
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("issue_accept", 64'(n < 50), 64'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    // Scramble operands so anything sampled after the handshake corrupts the result.
    req0_a = 16'hDEAD; req0_b = 16'hBEEF; req0_sub = ~req0_sub;
    req1_a = 16'hA5A5; req1_b = 16'h5A5A; req1_sub = ~req1_sub;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {rsp_valid, rsp_id, rsp_cout, rsp_ovf, rsp_sum, add_a, add_b, add_cin, req0_ready, req1_ready}, 64'd0);
    rst_n = 1'b1;

    // Both requesters valid continuously: grants alternate starting with 0.
    log_grants = 1'b1;
    exp0 = {1'b0, 16'h2233, 1'b0, 1'b0};
    exp1 = {1'b1, 16'h7FFF, 1'b1, 1'b1};
    req0_a = 16'h1234; req0_b = 16'h0FFF; req0_sub = 1'b0;
    req1_a = 16'h8000; req1_b = 16'h0001; req1_sub = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    n = 0;
    while (grant_log.size() < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    log_grants = 1'b0;
    check("arb_grant_count", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < grant_log.size()) check("arb_order", 64'(grant_log[i]), 64'(i % 2));
    check("arb_ready0_pulses", 64'(ready0_cnt), 64'd2);
    check("arb_ready1_pulses", 64'(ready1_cnt), 64'd2);
    drain("arb_drain");

    // Add with latency and carry-chain observation.
    issue(1'b0, 16'h1234, 16'h0FFF, 1'b0, {1'b0, 16'h2233, 1'b0, 1'b0});
    for (int k = 0; k < NIB; k++) begin
      @(negedge clk);
      cin_seq[k] = add_cin;
      check("lat_valid_low", 64'(rsp_valid), 64'd0);
    end
    @(negedge clk);
    check("lat_valid_high", 64'(rsp_valid), 64'd1);
    check("add_cin_seq", 64'(cin_seq), 64'(4'b1110));
    drain("add_drain");

    issue(1'b0, 16'hFFFF, 16'h0001, 1'b0, {1'b0, 16'h0000, 1'b1, 1'b0});
    drain("wrap_drain");
    issue(1'b0, 16'h7FFF, 16'h0001, 1'b0, {1'b0, 16'h8000, 1'b0, 1'b1});
    drain("ovf_drain");
    issue(1'b1, 16'h8000, 16'h0001, 1'b1, {1'b1, 16'h7FFF, 1'b1, 1'b1});
    drain("sub_ovf_drain");
    issue(1'b1, 16'h0003, 16'h0005, 1'b1, {1'b1, 16'hFFFE, 1'b0, 1'b0});
    drain("sub_borrow_drain");

    // Backpressure in DONE with a pending request from requester 0.
    rsp_ready = 1'b0;
    issue(1'b1, 16'h0003, 16'h0005, 1'b1, {1'b1, 16'hFFFE, 1'b0, 1'b0});
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_reach_done", 64'(rsp_valid), 64'd1);
    @(posedge clk); #1;
    exp0 = {1'b0, 16'h2233, 1'b0, 1'b0};
    req0_a = 16'h1234; req0_b = 16'h0FFF; req0_sub = 1'b0; req0_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold", {rsp_valid, rsp_id, rsp_cout, rsp_ovf, rsp_sum}, {1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFE});
      check("bp_ready_low", {req0_ready, req1_ready}, 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_still_done", {req0_ready, req1_ready}, 64'd0);
    @(negedge clk);
    check("bp_idle_accept", {req0_ready, req1_ready}, 64'b10);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drain("bp_drain");

    // Asynchronous reset in the middle of RUN drops the operation.
    issue(1'b1, 16'h1234, 16'h0FFF, 1'b0, {1'b1, 16'h2233, 1'b0, 1'b0});
    repeat (3) @(negedge clk);
    check("mid_run_nibble2", {add_a, add_b}, {4'h2, 4'hF});
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {rsp_valid, rsp_id, rsp_cout, rsp_ovf, rsp_sum, add_a, add_b, add_cin, req0_ready, req1_ready}, 64'd0);
    sb.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp0 = {1'b0, 16'h8000, 1'b0, 1'b1};
    exp1 = {1'b1, 16'h7FFF, 1'b1, 1'b1};
    req0_a = 16'h7FFF; req0_b = 16'h0001; req0_sub = 1'b0;
    req1_a = 16'h8000; req1_b = 16'h0001; req1_sub = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("post_reset_tie", {req0_ready, req1_ready}, 64'b10);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    n = 0;
    while (!req1_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("post_reset_req1_accept", 64'(req1_ready), 64'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    drain("post_reset_drain");
    repeat (4) @(negedge clk);

    check("never_both_ready", 64'(both_ready), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
